// File: rtl/bank_row_tracker_pkg.sv
// Shared constants and the access-class enum for the bank open-row tracker.
package bank_tracker_pkg;

    localparam int unsigned ROW_W_DEF  = 11;
    localparam int unsigned BANK_W_DEF = 2;
    localparam int unsigned IDLE_W_DEF = 8;

    typedef enum logic [1:0] {
        CLS_NONE,
        CLS_HIT,
        CLS_MISS,
        CLS_CONFLICT
    } access_cls_t;

endpackage

// File: rtl/bank_row_tracker_if.sv
// Address-path bus between the memory controller and the open-row tracker.
interface bank_row_tracker_if
    import bank_tracker_pkg::*;
#(
    parameter int unsigned ROW_W  = ROW_W_DEF,
    parameter int unsigned BANK_W = BANK_W_DEF
);
    localparam int unsigned NBANKS = 1 << BANK_W;

    logic [ROW_W-1:0]  row;
    logic [BANK_W-1:0] bank;
    logic              lookup;
    logic              open;
    logic              close;
    logic              close_all;
    logic              hit;
    logic              miss;
    logic              conflict;
    logic [NBANKS-1:0] open_mask;
    logic              close_req;
    logic [BANK_W-1:0] close_req_bank;

    modport master (
        output row, bank, lookup, open, close, close_all,
        input  hit, miss, conflict, open_mask, close_req, close_req_bank
    );

    modport slave (
        input  row, bank, lookup, open, close, close_all,
        output hit, miss, conflict, open_mask, close_req, close_req_bank
    );

endinterface

// File: rtl/bank_row_tracker_slot.sv
// One bank's open-row state: row register, valid bit and optional idle counter.
// Idle counter present only when BANK_IDLE_TIMEOUT_EN is defined.
module bank_row_slot
    import bank_tracker_pkg::*;
#(
    parameter int unsigned       ROW_W      = ROW_W_DEF,
    parameter int unsigned       IDLE_W     = IDLE_W_DEF,
    parameter logic [IDLE_W-1:0] IDLE_LIMIT = 8'd64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             do_open,
    input  logic             do_close,
    input  logic             do_close_all,
    input  logic             reload,
    input  logic [ROW_W-1:0] row_in,
    output logic             valid,
    output logic             match,
    output logic             expired
);

    logic [ROW_W-1:0] row_q;

    // Bank state update: close_all beats open, open beats close.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid <= 1'b0;
            row_q <= '0;
        end else if (do_close_all) begin
            valid <= 1'b0;
        end else if (do_open) begin
            valid <= 1'b1;
            row_q <= row_in;
        end else if (do_close) begin
            valid <= 1'b0;
        end
    end

    assign match = (row_q == row_in);

`ifdef BANK_IDLE_TIMEOUT_EN
    logic [IDLE_W-1:0] idle_cnt;

    // Idle countdown: reload on activate or page hit, saturate at zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idle_cnt <= '0;
        end else if ((do_open && !do_close_all) || reload) begin
            idle_cnt <= IDLE_LIMIT;
        end else if (valid && idle_cnt != '0) begin
            idle_cnt <= idle_cnt - 1'b1;
        end
    end

    assign expired = valid && (idle_cnt == '0);
`else
    logic unused_reload;
    assign unused_reload = reload;
    assign expired       = 1'b0;
`endif

endmodule

// File: rtl/bank_row_tracker.sv
// Multi-bank DRAM open-row tracker: per-bank slots, access classification,
// and (with BANK_IDLE_TIMEOUT_EN defined) lowest-index idle-close requests.
module bank_row_tracker
    import bank_tracker_pkg::*;
#(
    parameter int unsigned       ROW_W      = ROW_W_DEF,
    parameter int unsigned       BANK_W     = BANK_W_DEF,
    parameter int unsigned       IDLE_W     = IDLE_W_DEF,
    parameter logic [IDLE_W-1:0] IDLE_LIMIT = 8'd64
) (
    input  logic              sys_clk,
    input  logic              resl,
    bank_row_tracker_if.slave bus
);

    localparam int unsigned NBANKS = 1 << BANK_W;

    logic [NBANKS-1:0] sel;
    logic [NBANKS-1:0] valid_v;
    logic [NBANKS-1:0] match_v;
    logic [NBANKS-1:0] expired_v;
    logic [NBANKS-1:0] reload_v;
    access_cls_t       cls;

    // One-hot decode of the addressed bank.
    always_comb begin
        sel           = '0;
        sel[bus.bank] = 1'b1;
    end

    assign reload_v = {NBANKS{bus.lookup}} & sel & valid_v & match_v;

    for (genvar i = 0; i < NBANKS; i++) begin : g_slot
        bank_row_slot #(
            .ROW_W      (ROW_W),
            .IDLE_W     (IDLE_W),
            .IDLE_LIMIT (IDLE_LIMIT)
        ) u_slot (
            .clk          (sys_clk),
            .rst_n        (resl),
            .do_open      (bus.open && sel[i]),
            .do_close     (bus.close && sel[i]),
            .do_close_all (bus.close_all),
            .reload       (reload_v[i]),
            .row_in       (bus.row),
            .valid        (valid_v[i]),
            .match        (match_v[i]),
            .expired      (expired_v[i])
        );
    end

    // Classify the current access against pre-edge bank state.
    always_comb begin
        cls = CLS_NONE;
        if (bus.lookup) begin
            if (!valid_v[bus.bank]) begin
                cls = CLS_MISS;
            end else if (match_v[bus.bank]) begin
                cls = CLS_HIT;
            end else begin
                cls = CLS_CONFLICT;
            end
        end
    end

    assign bus.hit       = (cls == CLS_HIT);
    assign bus.miss      = (cls == CLS_MISS);
    assign bus.conflict  = (cls == CLS_CONFLICT);
    assign bus.open_mask = valid_v;

`ifdef BANK_IDLE_TIMEOUT_EN
    logic              any_expired;
    logic [BANK_W-1:0] low_idx;
    logic              close_req_q;
    logic [BANK_W-1:0] close_req_bank_q;

    // Priority encoder: scan downwards so the lowest expired index wins.
    always_comb begin
        any_expired = |expired_v;
        low_idx     = '0;
        for (int unsigned i = NBANKS; i > 0; i--) begin
            if (expired_v[i-1]) begin
                low_idx = BANK_W'(i - 1);
            end
        end
    end

    // Registered close request; stays up while the bank remains expired.
    always_ff @(posedge sys_clk or negedge resl) begin
        if (!resl) begin
            close_req_q      <= 1'b0;
            close_req_bank_q <= '0;
        end else begin
            close_req_q      <= any_expired;
            close_req_bank_q <= low_idx;
        end
    end

    assign bus.close_req      = close_req_q;
    assign bus.close_req_bank = close_req_bank_q;
`else
    logic unused_expired;
    assign unused_expired     = |expired_v;
    assign bus.close_req      = 1'b0;
    assign bus.close_req_bank = '0;
`endif

endmodule

// File: doc/bank_row_tracker.md
# bank_row_tracker

Multi-bank DRAM open-row tracker for the memory controller address path. Holds the open row of every bank and classifies each access as a page hit, a bank miss (bank closed), or a row conflict (bank open on another row). Optionally issues per-bank idle-close (precharge) requests. Successor to the single-bank row-match comparator: parametrised row width and bank count, explicit per-bank close, hit/miss/conflict classification.

## Interface
Parameters:
- ROW_W, 11: row address width.
- BANK_W, 2: bank select width; NBANKS = 2**BANK_W.
- IDLE_W, 8: idle counter width (used only with the configuration macro).
- IDLE_LIMIT, 8'd64: idle cycles before a close request; must fit IDLE_W.

Ports:
- sys_clk  in  1  system clock; all state on rising edge.
- resl  in  1  asynchronous active-low reset.
- row  in  ROW_W  row address of current access.
- bank  in  BANK_W  bank of current access.
- lookup  in  1  qualifies row/bank for classification.
- open  in  1  activate strobe: record row as open in bank.
- close  in  1  precharge strobe for bank.
- close_all  in  1  precharge-all / refresh: close every bank.
- hit  out  1  lookup & bank open & row equal.
- miss  out  1  lookup & bank closed.
- conflict  out  1  lookup & bank open & row differs.
- open_mask  out  NBANKS  per-bank valid bits.
- close_req  out  1  some bank idle-expired.
- close_req_bank  out  BANK_W  lowest-index expired bank.

## Operation
- Per bank: row register (ROW_W), valid bit, optional idle counter.
- hit/miss/conflict combinational from lookup, bank, row and registered state; exactly one high when lookup=1, all low when lookup=0.
- Classification uses state before the current edge: lookup in the same cycle as open/close on that bank sees the old state.
- Update priority per bank each edge: close_all > open (addressed bank) > close (addressed bank) > hold.
  - open: row register <= row, valid <= 1.
  - close: valid <= 0; row register unchanged.
  - open and close in the same cycle: open wins (sequenced precharge+activate).
  - close_all with open same cycle: all banks closed, open discarded.
- Row registers load only on open; never cleared except by reset.
- open_mask = valid bits, registered.
- Idle counters (macro on): reload to IDLE_LIMIT on open or on lookup hit to that bank; decrement each cycle while valid and nonzero; saturate at 0. Bank is expired when valid and counter==0.
- close_req = OR of expired; close_req_bank = lowest expired index, 0 when none. Request holds until that bank is closed, reopened, or close_all; no separate ack.
- IDLE_LIMIT=0: bank expires the cycle after open.

## Timing
- Reset (resl low, async): all valid=0, row registers=0, counters=0; open_mask=0, close_req=0, close_req_bank=0; hit/miss/conflict follow lookup (miss=lookup).
- Classification latency 0 cycles (combinational); state updates visible the cycle after the strobe.
- Reset released mid-sequence: strobes in the first cycle after deassertion act normally; no recovery state.
- Expiry: open at edge N -> close_req at edge N+IDLE_LIMIT+1 if no intervening hit.
- close_req drops the cycle after the close edge for that bank; next expired bank then presented.

## Configuration
- BANK_IDLE_TIMEOUT_EN defined: idle counters, close_req and close_req_bank implemented as above.
- Undefined: no counters synthesised; close_req=0, close_req_bank=0 constant; IDLE_W/IDLE_LIMIT ignored. All other behaviour identical.

## Structure
- Package bank_tracker_pkg: default ROW_W/BANK_W/IDLE_W constants, access-class enum (CLS_NONE, CLS_HIT, CLS_MISS, CLS_CONFLICT) for bench use.
- One sub-module bank_row_slot: row register, valid bit, idle counter, per-bank match/expired outputs; instantiated NBANKS times with generate. Top holds decode, class mux, priority encoder.

## Test plan
- Reset, then lookup bank=2 row=0x155 -> miss=1, hit=0, conflict=0, open_mask=4'b0000.
- open bank=1 row=0x123; next cycle lookup bank=1 row=0x123 -> hit=1; row=0x124 -> conflict=1; open_mask=4'b0010.
- open bank=3 row=0x7FF with lookup bank=3 row=0x7FF same cycle -> miss=1 that cycle, hit=1 next cycle.
- open and close bank=0 same cycle -> bank 0 valid; close_all with open bank=2 -> open_mask=0.
- Macro on, IDLE_LIMIT=4: open bank=1 at edge N -> close_req=1, close_req_bank=1 at N+5; lookup hit at N+2 delays to N+7; close bank=1 -> close_req=0 next cycle.
- Banks 1 and 3 expired together -> close_req_bank=1; after close bank=1 -> close_req_bank=3; reset asserted mid-request -> close_req=0 immediately.
